// File: rtl/core_mem_arb_pkg.sv
// core_pkg: shared types and constants for the core_mem_arb slice.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_ISSUE, ARB_WAIT)
//   MEM_READ / MEM_WRITE : encoding of the r_w direction bit
//   idx_w()     : width of a port index for a given port count (min 1)
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_arb_if.sv
// core_mem_arb_if: requester-side and memory-side bus of the arbiter.
//   req_valid/req_ready/req_addr/req_wdata/req_r_w : per-port request channel
//   rsp_valid/rsp_rdata                            : per-port completion pulse + read data
//   mem_enable/mem_r_w/mem_address/mem_input       : memory access strobe and payload
//   mem_output/mem_ready                           : memory read data and completion
//   req_lock (only with MEM_ARB_LOCK_EN)           : per-port ownership-lock request
// Modports: slave = arbiter, master = requesters + memory model.
interface core_mem_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_ready;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]             req_r_w;
`ifdef MEM_ARB_LOCK_EN
  logic [NUM_PORTS-1:0]             req_lock;
`endif
  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [DATA_W-1:0]                rsp_rdata;
  logic                             mem_enable;
  logic                             mem_r_w;
  logic [ADDR_W-1:0]                mem_address;
  logic [DATA_W-1:0]                mem_input;
  logic [DATA_W-1:0]                mem_output;
  logic                             mem_ready;

  modport slave (
`ifdef MEM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_addr, req_wdata, req_r_w, mem_output, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_enable, mem_r_w, mem_address, mem_input
  );

  modport master (
`ifdef MEM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_addr, req_wdata, req_r_w, mem_output, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_enable, mem_r_w, mem_address, mem_input
  );
endinterface

// File: rtl/core_mem_arb_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req_i : request vector
//   ptr_i : highest-priority port this cycle
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted port
//   any_o : at least one request present
module rr_picker import core_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);
  logic [NUM_PORTS-1:0] req_rot;
  logic [NUM_PORTS-1:0] first_rot;
  logic [NUM_PORTS:0]   seen;
  logic [IDX_W-1:0]     idx_acc [NUM_PORTS+1];

  // Rotate so the pointer port sits at bit 0, take the lowest set bit,
  // then rotate the one-hot result back into port order.
  assign req_rot    = NUM_PORTS'({req_i, req_i} >> ptr_i);
  assign seen[0]    = 1'b0;
  assign idx_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pri
      assign first_rot[gi]  = req_rot[gi] & ~seen[gi];
      assign seen[gi+1]     = seen[gi] | req_rot[gi];
      assign idx_acc[gi+1]  = idx_acc[gi] | (gnt_o[gi] ? IDX_W'(gi) : '0);
    end
  endgenerate

  assign gnt_o = NUM_PORTS'({first_rot, first_rot} >> (NUM_PORTS - int'(ptr_i)));
  assign idx_o = idx_acc[NUM_PORTS];
  assign any_o = seen[NUM_PORTS];
endmodule

// File: rtl/core_mem_arb.sv
// core_mem_arb: round-robin arbiter of NUM_PORTS requesters onto a single
// memory port, one transaction outstanding (accept -> access -> response).
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : core_mem_arb_if.slave (request, response and memory signals)
// Optional feature: define MEM_ARB_LOCK_EN to add req_lock, which lets a
// port keep ownership across consecutive requests.
module core_mem_arb import core_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  core_mem_arb_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 rw_q, rw_d;
  logic                 lock_q, lock_d;          // lock bit of the transaction in flight
  logic                 own_lock_q, own_lock_d;  // owner_q holds the bus after completion
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic [NUM_PORTS-1:0] lock_w;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 grant_any;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_PORTS-1:0] grant_vec;
  logic                 active;

`ifdef MEM_ARB_LOCK_EN
  assign lock_w = bus.req_lock;
`else
  assign lock_w = '0;
`endif

  rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_picker (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    lock_d      = lock_q;
    own_lock_d  = own_lock_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    grant_any   = 1'b0;
    grant_idx   = pick_idx;
    grant_vec   = '0;
    case (state_q)
      ARB_IDLE: begin
        // No grant in the cycle that presents a response: completion and
        // the next accept are always in different cycles.
        if (~|rsp_valid_q) begin
          if (own_lock_q && bus.req_valid[owner_q]) begin
            grant_any = 1'b1;
            grant_idx = owner_q;
            grant_vec = NUM_PORTS'(1) << owner_q;
          end else if (pick_any) begin
            grant_any = 1'b1;
            grant_idx = pick_idx;
            grant_vec = pick_gnt;
          end
        end
        if (grant_any) begin
          state_d    = ARB_ISSUE;
          owner_d    = grant_idx;
          addr_d     = bus.req_addr[grant_idx];
          wdata_d    = bus.req_wdata[grant_idx];
          rw_d       = bus.req_r_w[grant_idx];
          lock_d     = lock_w[grant_idx];
          own_lock_d = 1'b0;
          // A locked grant leaves the rotation where it was.
          if (!lock_w[grant_idx]) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
      end
      ARB_ISSUE, ARB_WAIT: begin
        if (bus.mem_ready) begin
          state_d     = ARB_IDLE;
          rsp_valid_d = NUM_PORTS'(1) << owner_q;
          rsp_rdata_d = (rw_q == MEM_READ) ? bus.mem_output : '0;
          own_lock_d  = lock_q;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= MEM_READ;
      lock_q      <= 1'b0;
      own_lock_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      lock_q      <= lock_d;
      own_lock_q  <= own_lock_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign active          = (state_q != ARB_IDLE);
  // req_ready is combinational from req_valid, so it is forced low while
  // reset is held to keep every output at zero during reset.
  assign bus.req_ready   = reset ? grant_vec : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.mem_enable  = active;
  assign bus.mem_r_w     = active && (rw_q == MEM_WRITE);
  assign bus.mem_address = active ? addr_q : '0;
  assign bus.mem_input   = active ? wdata_q : '0;
endmodule

// File: doc/core_mem_arb.md
CORE_MEM_ARB -- requirements
Module: core_mem_arb

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requester channels (range 1..8).
REQ-002 Parameter ADDR_W, default 32, memory address width.
REQ-003 Parameter DATA_W, default 32, memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 req_valid  input  NUM_PORTS  per-port request present.
REQ-007 req_ready  output  NUM_PORTS  per-port request accepted this cycle.
REQ-008 req_addr  input  NUM_PORTS x ADDR_W  per-port address.
REQ-009 req_wdata  input  NUM_PORTS x DATA_W  per-port write data.
REQ-010 req_r_w  input  NUM_PORTS  per-port direction, 1 = write, 0 = read.
REQ-011 rsp_valid  output  NUM_PORTS  one-cycle completion pulse to the owning port.
REQ-012 rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit is high.
REQ-013 mem_enable  output  1  memory access strobe.
REQ-014 mem_r_w  output  1  memory direction, 1 = write.
REQ-015 mem_address  output  ADDR_W  memory address.
REQ-016 mem_input  output  DATA_W  memory write data.
REQ-017 mem_output  input  DATA_W  memory read data.
REQ-018 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-020 IDLE: when any req_valid is high, the arbiter selects one port round-robin, asserts that port's req_ready for one cycle, latches addr/wdata/r_w/port index, and goes to ISSUE.
REQ-021 Round-robin: search starts at rr_ptr; after a grant to port k, rr_ptr = (k+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
REQ-022 At most one req_ready bit is high in any cycle; req_ready is never high outside IDLE.
REQ-023 ISSUE and WAIT: mem_enable = 1, with mem_address/mem_r_w/mem_input driven from the latched request and held stable until mem_ready.
REQ-024 ISSUE with mem_ready = 1: transaction completes; otherwise the FSM goes to WAIT and remains there until mem_ready = 1.
REQ-025 On completion, rsp_valid[owner] pulses for exactly one cycle (next cycle), rsp_rdata = mem_output captured at mem_ready for reads, and rsp_rdata = 0 for writes; the FSM returns to IDLE.
REQ-026 Minimum latency: accept cycle N, memory access in cycle N+1, rsp_valid in N+2; throughput is one transaction per 3 cycles with zero-wait memory.
REQ-027 A completion and a new grant never occur in the same cycle.
REQ-028 A requester deasserting req_valid before its req_ready is legal; the request is not granted.
REQ-029 mem_ready while in IDLE is ignored.

Reset
REQ-030 While reset = 0: state = IDLE, rr_ptr = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, mem_enable = 0, mem_r_w = 0, mem_address = 0, mem_input = 0.
REQ-031 Reset asserted mid-transaction aborts it with no rsp_valid; the first grant after reset goes to the lowest-index valid port.

Configuration
REQ-032 Macro MEM_ARB_LOCK_EN adds an input req_lock (NUM_PORTS bits).
REQ-033 With MEM_ARB_LOCK_EN: on completion of a granted request with req_lock set, the same port keeps ownership and is granted again in IDLE ahead of round-robin if it is valid; rr_ptr is frozen until a grant with lock clear.
REQ-034 Without MEM_ARB_LOCK_EN: no req_lock port; pure round-robin.

Structure
REQ-035 Shared package core_pkg holds the FSM state enum (ARB_IDLE, ARB_ISSUE, ARB_WAIT) and constants MEM_READ = 0, MEM_WRITE = 1.
REQ-036 One sub-module rr_picker (combinational round-robin select: request vector + pointer -> one-hot grant + index).

Verification
REQ-037 NUM_PORTS = 2, both ports request a read at 0x100/0x200, mem_ready tied to 1 -> grants go to port0 then port1; rsp_valid[0] is set two cycles after the grant with rsp_rdata = mem_output.
REQ-038 Port1 writes 0xDEADBEEF to 0x40 with mem_ready low for 3 cycles -> mem_address/mem_input held stable for 4 cycles; a single rsp_valid[1] follows with rsp_rdata = 0.
REQ-039 NUM_PORTS = 4, all ports valid continuously -> grant order 0,1,2,3,0 with no port granted twice consecutively.
REQ-040 reset driven low during WAIT -> all outputs 0 immediately (async); no rsp_valid; after release, port0 is granted first.
REQ-041 MEM_ARB_LOCK_EN, port2 issues 3 locked requests while port0 is valid -> port2 is granted 3 times before port0.
REQ-042 A request withdrawn before grant (req_valid high for one cycle while the FSM is busy) -> no grant and no memory access for that port.
